// File: rtl/mem_dma_pkg.sv
// Shared definitions for the word-copy DMA engine.
//   state_t     : FSM state encoding (IDLE, READ, WRITE, GAP)
//   WSTRB_WORD  : byte strobe for a full-word write
//   WSTRB_NONE  : byte strobe presented during a read
//   WORD_BYTES  : pointer increment per copied word
//   word_align  : clears the byte-offset bits of an address
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [3:0]  WSTRB_WORD = 4'b1111;
    localparam logic [3:0]  WSTRB_NONE = 4'b0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/mem_dma_timeout.sv
// Bus-phase watchdog: a saturating down-counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : reload with TIMEOUT_CYCLES (start of a bus phase)
//   dec        : one stalled cycle (request high, no completion)
//   expire     : this stalled cycle is the TIMEOUT_CYCLES-th in a row
module mem_dma_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Expiry is flagged combinationally so the FSM can abort on the very
    // edge that would complete the last allowed stalled cycle.
    assign expire = dec && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_dma.sv
// Memory-to-memory word copy engine with a single shared request bus.
// Each word is a READ phase, a one-cycle GAP, a WRITE phase and another GAP.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : copy request, sampled only in IDLE
//   src_addr, dst_addr  : byte addresses (low two bits ignored)
//   len                 : number of 32-bit words to copy
//   busy, done, error   : status (done is a pulse, error is sticky)
//   mem_valid/mem_ready : request / one-cycle completion handshake
//   mem_addr, mem_wdata, mem_wstrb : request payload (wstrb 0 = read)
//   mem_rdata           : read data, valid with mem_ready
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    state_t           state, state_nxt;
    logic             next_write, next_write_nxt;
    logic [31:0]      src_ptr, src_ptr_nxt;
    logic [31:0]      dst_ptr, dst_ptr_nxt;
    logic [31:0]      data_reg, data_reg_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             busy_nxt, done_nxt, error_nxt, mem_valid_nxt;
    logic [31:0]      mem_addr_nxt, mem_wdata_nxt;
    logic [3:0]       mem_wstrb_nxt;
    logic             to_load, to_dec, to_expire;

    // mem_valid is always high in READ/WRITE, so a stalled cycle is simply
    // a bus-phase state without a completion.
    assign to_dec = ((state == READ) || (state == WRITE)) && !mem_ready;

    mem_dma_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (to_load),
        .dec    (to_dec),
        .expire (to_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            next_write <= 1'b0;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            data_reg   <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            state      <= state_nxt;
            next_write <= next_write_nxt;
            src_ptr    <= src_ptr_nxt;
            dst_ptr    <= dst_ptr_nxt;
            data_reg   <= data_reg_nxt;
            remaining  <= remaining_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            mem_valid  <= mem_valid_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_wstrb  <= mem_wstrb_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port comes from a flop.
    always_comb begin
        state_nxt      = state;
        next_write_nxt = next_write;
        src_ptr_nxt    = src_ptr;
        dst_ptr_nxt    = dst_ptr;
        data_reg_nxt   = data_reg;
        remaining_nxt  = remaining;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        error_nxt      = error;
        mem_valid_nxt  = mem_valid;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        mem_wstrb_nxt  = mem_wstrb;
        to_load        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    src_ptr_nxt   = word_align(src_addr);
                    dst_ptr_nxt   = word_align(dst_addr);
                    remaining_nxt = len;
                    error_nxt     = 1'b0;
                    if (len != '0) begin
                        state_nxt     = READ;
                        busy_nxt      = 1'b1;
                        mem_valid_nxt = 1'b1;
                        mem_addr_nxt  = word_align(src_addr);
                        mem_wstrb_nxt = WSTRB_NONE;
                        to_load       = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            READ: begin
                // A completion wins over a timeout landing on the same edge.
                if (mem_ready) begin
                    data_reg_nxt   = mem_rdata;
                    next_write_nxt = 1'b1;
                    state_nxt      = GAP;
                    mem_valid_nxt  = 1'b0;
                end else if (to_expire) begin
                    state_nxt     = IDLE;
                    busy_nxt      = 1'b0;
                    error_nxt     = 1'b1;
                    mem_valid_nxt = 1'b0;
                end
            end

            WRITE: begin
                if (mem_ready) begin
                    remaining_nxt = remaining - LEN_W'(1);
                    src_ptr_nxt   = src_ptr + WORD_BYTES;
                    dst_ptr_nxt   = dst_ptr + WORD_BYTES;
                    mem_valid_nxt = 1'b0;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt      = GAP;
                        next_write_nxt = 1'b0;
                    end
                end else if (to_expire) begin
                    state_nxt     = IDLE;
                    busy_nxt      = 1'b0;
                    error_nxt     = 1'b1;
                    mem_valid_nxt = 1'b0;
                end
            end

            GAP: begin
                // Exactly one idle bus cycle, then launch the pending phase.
                mem_valid_nxt = 1'b1;
                to_load       = 1'b1;
                if (next_write) begin
                    state_nxt     = WRITE;
                    mem_addr_nxt  = dst_ptr;
                    mem_wdata_nxt = data_reg;
                    mem_wstrb_nxt = WSTRB_WORD;
                end else begin
                    state_nxt     = READ;
                    mem_addr_nxt  = src_ptr;
                    mem_wstrb_nxt = WSTRB_NONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
